spi_cfg_master: RTL and testbench

//  SPI host that configures the SPI register peripheral: writes output-enable, PWM-enable
//  and duty-cycle registers. Two on-chip requesters are arbitrated round-robin, one at a time.

---
 rtl/spi_cfg_master_if.sv | 23 ++
 rtl/spi_cfg_master.sv | 133 +++++++++++++
 tb/tb_spi_cfg_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_master_if.sv
// Request/status bundle between on-chip requesters and the SPI configuration master.
// The master modport is the requester side; the slave modport is the SPI master block.
interface spi_cfg_master_if;
    logic [1:0] req_valid;
    logic [6:0] req_addr0;
    logic [7:0] req_data0;
    logic [6:0] req_addr1;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       busy;
    logic       done;
    logic       done_id;

    modport master (
        output req_valid, req_addr0, req_data0, req_addr1, req_data1,
        input  req_ready, busy, done, done_id
    );

    modport slave (
        input  req_valid, req_addr0, req_data0, req_addr1, req_data1,
        output req_ready, busy, done, done_id
    );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI mode-0 host: arbitrates two register-write requesters round-robin and sends each
// accepted request as one 16-bit write frame {1, addr[6:0], data[7:0]}, MSB first.
module spi_cfg_master #(
    parameter int CLK_DIV  = 4,
    parameter int GAP_MULT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_cfg_master_if.slave  req,
    output logic             sclk,
    output logic             ncs,
    output logic             copi
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] GAP_LAST  = 5'(GAP_MULT - 1);

    state_t      state, state_nx;
    logic [7:0]  hcnt;
    logic [4:0]  bcnt;
    logic        ph;
    logic        rr_ptr;
    logic        id;
    logic [15:0] sr;
    logic        any_req, gnt, half_end;
    logic [1:0]  ready_nx;
    logic        busy_nx, done_nx, ncs_nx, sclk_nx, copi_nx;

    assign any_req  = |req.req_valid;
    assign half_end = (hcnt == HALF_LAST);

    always_comb begin
        gnt = rr_ptr;
        if (req.req_valid == 2'b01)
            gnt = 1'b0;
        else if (req.req_valid == 2'b10)
            gnt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (any_req) state_nx = SETUP;
            SETUP: if (half_end) state_nx = SHIFT;
            SHIFT: if (half_end && ph && bcnt == 5'd15) state_nx = GAP;
            GAP:   if (half_end && bcnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ph=0 is the sclk-high half of a bit, ph=1 the low half; in GAP bcnt counts D-cycle units
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            bcnt   <= '0;
            ph     <= 1'b0;
            rr_ptr <= 1'b0;
            id     <= 1'b0;
        end else begin
            if (state == IDLE || state_nx != state) begin
                hcnt <= '0;
                bcnt <= '0;
                ph   <= 1'b0;
            end else if (half_end) begin
                hcnt <= '0;
                if (state == SHIFT) begin
                    ph <= ~ph;
                    if (ph)
                        bcnt <= bcnt + 5'd1;
                end else if (state == GAP) begin
                    bcnt <= bcnt + 5'd1;
                end
            end else begin
                hcnt <= hcnt + 8'd1;
            end
            if (state == IDLE && any_req) begin
                rr_ptr <= ~gnt;
                id     <= gnt;
            end
        end
    end

    // Frame shifts on the sclk falling edge so copi is stable around each rising edge
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req)
            sr <= {1'b1, gnt ? req.req_addr1 : req.req_addr0,
                         gnt ? req.req_data1 : req.req_data0};
        else if (state == SHIFT && half_end && !ph)
            sr <= {sr[14:0], 1'b0};
    end

    always_comb begin
        ready_nx = 2'b00;
        if (state == IDLE && any_req)
            ready_nx = gnt ? 2'b10 : 2'b01;
        busy_nx = (state_nx != IDLE);
        done_nx = (state == GAP && hcnt == 8'd0 && bcnt == 5'd0);
        ncs_nx  = !(state == SETUP || state == SHIFT);
        sclk_nx = (state == SHIFT && !ph);
        copi_nx = (state == SETUP || state == SHIFT) ? sr[15] : 1'b0;
    end

    // Every pin is a flop copy of the decoded state, so all durations carry through intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req.req_ready <= 2'b00;
            req.busy      <= 1'b0;
            req.done      <= 1'b0;
            ncs           <= 1'b1;
            sclk          <= 1'b0;
            copi          <= 1'b0;
        end else begin
            req.req_ready <= ready_nx;
            req.busy      <= busy_nx;
            req.done      <= done_nx;
            ncs           <= ncs_nx;
            sclk          <= sclk_nx;
            copi          <= copi_nx;
        end
    end

    assign req.done_id = id;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: stimulus pushes expected frames from a round-robin model,
// a bus monitor acting as the SPI register peripheral pops and scores every frame.
module tb_spi_cfg_master;
    localparam int D  = 4;
    localparam int GM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk, ncs, copi;

    spi_cfg_master_if bus();

    spi_cfg_master #(.CLK_DIV(D), .GAP_MULT(GM)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus), .sclk(sclk), .ncs(ncs), .copi(copi)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; logic [15:0] word; } exp_t;
    exp_t expq[$];

    int total = 0;
    int bad = 0;
    logic model_ptr = 1'b0;
    logic [7:0] shadow [128] = '{default: 8'h00};
    logic [7:0] periph [128] = '{default: 8'h00};
    logic [7:0] snap [128];
    int rises = 0;
    int stray_sclk = 0;
    logic [15:0] last_cap = 16'h0;

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor and peripheral model
    logic p_ncs = 1'b1, p_sclk = 1'b0, last_gnt = 1'b0;
    logic [1:0] p_rdy = 2'b00;
    logic [15:0] cap = 16'h0;
    bit in_frame = 0, seen_frame = 0, busy_ok = 1, acc_valid = 0;
    int low_cnt = 0, hi_cnt = 0, acc_gap = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; seen_frame = 0; acc_valid = 0; rises = 0;
            p_ncs = 1'b1; p_sclk = 1'b0; p_rdy = 2'b00;
        end else begin
            acc_gap++;
            if (bus.req_ready != 2'b00) begin
                chk("ready_onehot", $onehot(bus.req_ready), bus.req_ready, 1);
                chk("ready_single_cycle", p_rdy == 2'b00, p_rdy, 0);
                if (acc_valid)
                    chk("accept_spacing", acc_gap >= 1 + 33*D + GM*D, acc_gap, 1 + 33*D + GM*D);
                acc_valid = 1; acc_gap = 0; last_gnt = bus.req_ready[1];
            end
            if (p_ncs && !ncs) begin
                if (seen_frame) chk("gap_ncs_high", hi_cnt >= GM*D, hi_cnt, GM*D);
                in_frame = 1; low_cnt = 0; rises = 0; cap = 16'h0; busy_ok = 1;
            end
            if (!p_ncs && ncs) begin
                chk("done_at_ncs_rise", bus.done == 1'b1, bus.done, 1);
                if (in_frame) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_frame", 1'b0, cap, 0);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("frame_word", cap == e.word, cap, e.word);
                        chk("done_id", bus.done_id == e.id, bus.done_id, e.id);
                        chk("grant_idx", last_gnt == e.id, last_gnt, e.id);
                        chk("ncs_low_cycles", low_cnt == 33*D, low_cnt, 33*D);
                        chk("sclk_rises", rises == 16, rises, 16);
                        chk("busy_in_frame", busy_ok, busy_ok, 1);
                    end
                    if (rises == 16 && cap[15]) periph[cap[14:8]] = cap[7:0];
                    last_cap = cap;
                end
                in_frame = 0; seen_frame = 1; hi_cnt = 0;
            end else if (bus.done) begin
                chk("stray_done", 1'b0, 1, 0);
            end
            if (!ncs) begin
                low_cnt++;
                if (!bus.busy) busy_ok = 0;
                if (sclk && !p_sclk) begin
                    cap = {cap[14:0], copi};
                    rises++;
                end
            end else begin
                hi_cnt++;
                if (sclk) stray_sclk++;
            end
            p_ncs = ncs; p_sclk = sclk; p_rdy = bus.req_ready;
        end
    end

    task automatic push_exp(input logic id, input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.word = {1'b1, a, d};
        expq.push_back(e);
        shadow[a] = d;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || bus.busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 5000, n, 5000);
    endtask

    // Drops each requester's valid on its ready pulse and scrambles its inputs afterwards
    task automatic wait_accepts();
        int n = 0;
        while (bus.req_valid != 2'b00 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.req_ready[0]) begin
                bus.req_valid[0] = 1'b0; bus.req_addr0 = 7'($urandom); bus.req_data0 = 8'($urandom);
            end
            if (bus.req_ready[1]) begin
                bus.req_valid[1] = 1'b0; bus.req_addr1 = 7'($urandom); bus.req_data1 = 8'($urandom);
            end
        end
        chk("accept_timeout", bus.req_valid == 2'b00, n, 3000);
        bus.req_valid = 2'b00;
    endtask

    task automatic issue(input logic [1:0] mask, input logic [6:0] a0, input logic [7:0] d0,
                         input logic [6:0] a1, input logic [7:0] d1);
        wait_drain();
        @(negedge clk);
        bus.req_addr0 = a0; bus.req_data0 = d0;
        bus.req_addr1 = a1; bus.req_data1 = d1;
        bus.req_valid = mask;
        if (mask == 2'b11) begin
            push_exp(model_ptr, model_ptr ? a1 : a0, model_ptr ? d1 : d0);
            push_exp(~model_ptr, model_ptr ? a0 : a1, model_ptr ? d0 : d1);
        end else if (mask == 2'b01) begin
            push_exp(1'b0, a0, d0); model_ptr = 1'b1;
        end else if (mask == 2'b10) begin
            push_exp(1'b1, a1, d1); model_ptr = 1'b0;
        end
        wait_accepts();
    endtask

    task automatic stream0(input int frames);
        int k = 0;
        int n = 0;
        logic [6:0] a;
        logic [7:0] d;
        wait_drain();
        @(negedge clk);
        a = 7'($urandom); d = 8'($urandom);
        bus.req_addr0 = a; bus.req_data0 = d; bus.req_valid = 2'b01;
        push_exp(1'b0, a, d);
        model_ptr = 1'b1;
        while (k < frames && n < 20000) begin
            @(negedge clk);
            n++;
            if (bus.req_ready[0]) begin
                k++;
                a = 7'($urandom); d = 8'($urandom);
                bus.req_addr0 = a; bus.req_data0 = d;
                if (k < frames) push_exp(1'b0, a, d);
                else bus.req_valid = 2'b00;
            end
        end
        chk("stream_timeout", k == frames, k, frames);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        int n;
        int diff;
        bus.req_valid = 2'b00;
        bus.req_addr0 = 7'h0; bus.req_data0 = 8'h0;
        bus.req_addr1 = 7'h0; bus.req_data1 = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs == 1'b1, ncs, 1);
        chk("rst_sclk", sclk == 1'b0, sclk, 0);
        chk("rst_copi", copi == 1'b0, copi, 0);
        chk("rst_ready", bus.req_ready == 2'b00, bus.req_ready, 0);
        chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
        chk("rst_done", bus.done == 1'b0, bus.done, 0);
        chk("rst_done_id", bus.done_id == 1'b0, bus.done_id, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_busy", bus.busy == 1'b0 && ncs == 1'b1, {bus.busy, ncs}, 1);

        // Both at once: req0 first, then req1; re-raising both favours req0 again
        issue(2'b11, 7'h11, 8'h22, 7'h33, 8'h44);
        issue(2'b11, 7'h55, 8'h66, 7'h77, 8'h08);
        wait_drain();

        // Peripheral integration
        for (int i = 0; i < 128; i++) snap[i] = periph[i];
        issue(2'b01, 7'h00, 8'hA5, 7'h00, 8'h00);
        issue(2'b10, 7'h00, 8'h00, 7'h04, 8'h3C);
        wait_drain();
        chk("periph_en_reg_out", periph[0] == 8'hA5, periph[0], 8'hA5);
        chk("periph_pwm_duty", periph[4] == 8'h3C, periph[4], 8'h3C);
        diff = 0;
        for (int i = 1; i < 128; i++)
            if (i != 4 && periph[i] != snap[i]) diff++;
        chk("periph_others_unchanged", diff == 0, diff, 0);

        // Single write with a known wire pattern
        issue(2'b01, 7'h04, 8'h80, 7'h00, 8'h00);
        wait_drain();
        chk("t1_copi_stream", last_cap == 16'h8480, last_cap, 16'h8480);

        // req1 alone, then both: pointer alternation hands the next grant to req0
        issue(2'b10, 7'h12, 8'h34, 7'h56, 8'h78);
        issue(2'b11, 7'h7F, 8'hFF, 7'h00, 8'h00);

        stream0(4);

        // A request withdrawn before it can be granted must never be framed
        issue(2'b01, 7'h2A, 8'h5A, 7'h00, 8'h00);
        @(negedge clk);
        bus.req_addr1 = 7'h6B; bus.req_data1 = 8'hC3; bus.req_valid = 2'b10;
        repeat (20) @(negedge clk);
        bus.req_valid = 2'b00;
        wait_drain();
        repeat (20) @(negedge clk);

        for (int r = 0; r < 20; r++)
            issue(2'($urandom_range(1, 3)), 7'($urandom), 8'($urandom), 7'($urandom), 8'($urandom));
        wait_drain();

        // Reset in the middle of a frame
        @(negedge clk);
        bus.req_addr0 = 7'h01; bus.req_data0 = 8'h99; bus.req_valid = 2'b01;
        wait_accepts();
        n = 0;
        while (rises < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit7", rises >= 7, rises, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ncs", ncs == 1'b1, ncs, 1);
        chk("abort_sclk", sclk == 1'b0, sclk, 0);
        chk("abort_copi", copi == 1'b0, copi, 0);
        chk("abort_busy", bus.busy == 1'b0, bus.busy, 0);
        chk("abort_done", bus.done == 1'b0, bus.done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        issue(2'b11, 7'h0A, 8'h0B, 7'h0C, 8'h0D);
        issue(2'b01, 7'h00, 8'h00, 7'h00, 8'h00);
        wait_drain();
        repeat (30) @(negedge clk);

        chk("no_sclk_while_ncs_high", stray_sclk == 0, stray_sclk, 0);
        chk("queue_empty", expq.size() == 0, expq.size(), 0);
        diff = 0;
        for (int i = 0; i < 128; i++)
            if (periph[i] != shadow[i]) diff++;
        chk("periph_matches_model", diff == 0, diff, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
